store_merge_unit: RTL and testbench
===================================

// Module: store_merge_unit
// PURPOSE
//  Write-side counterpart of the immediate/load extender: narrows sb/sh/sw
//  store data into 32-bit word-only memory. Byte and half stores use a
//  read-modify-write (read word, merge lanes, write back). Word stores write
//  directly. Sits between the MEM stage and the data memory port.
// PARAMETERS
//  ADDR_W  32  byte-address width of st_addr and mem_addr
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       synchronous, active-high
//  st_valid    in   1       store request valid
//  st_ready    out  1       unit idle; request accepted when st_valid&st_ready
//  st_size     in   2       00 byte, 01 half, 10 word, 11 illegal
//  st_addr     in   ADDR_W  byte address of store
//  st_data     in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  mem_req     out  1       memory access request, held until mem_ack
//  mem_we      out  1       1 = write, 0 = read
//  mem_addr    out  ADDR_W  word address, {st_addr[ADDR_W-1:2],2'b00}
//  mem_wdata   out  32      merged write word
//  mem_rdata   in   32      read word, valid when mem_ack & ~mem_we
//  mem_ack     in   1       completes the current mem_req (may arrive same cycle)
//  done        out  1       one-cycle pulse: store committed
//  misaligned  out  1       one-cycle pulse: request rejected, no memory access
// BEHAVIOUR
//  - Reset: state IDLE; mem_req, mem_we, mem_addr, mem_wdata, done, misaligned = 0;
//    st_ready = 1 from the first cycle after reset. Reset mid-operation aborts:
//    next cycle mem_req = 0 and no write is issued.
//  - All outputs are registered. st_ready = (state == IDLE).
//  - FSM: IDLE, RD, WR.
//    IDLE: on accept, latch size, addr, and data.
//      misaligned (half & addr[0], word & addr[1:0]!=0, or size 11) -> stay IDLE;
//        misaligned=1 next cycle.
//      word -> WR: mem_wdata = st_data.
//      byte or half -> RD.
//    RD: mem_req=1, mem_we=0 until mem_ack; capture mem_rdata, merge -> WR.
//    WR: mem_req=1, mem_we=1 until mem_ack -> IDLE; done=1 the cycle after ack.
//  - Merge is little-endian. Byte offset k = addr[1:0] replaces bits [8k+7:8k]
//    with data[7:0]. A half at offset 0 replaces [15:0]; at offset 2 it
//    replaces [31:16]. All other bits come from mem_rdata.
//  - mem_addr and mem_wdata stay stable while mem_req is high. mem_ack with
//    mem_req low is ignored.
//  - st_valid while busy is ignored and not queued; the requester holds until st_ready.
//  - Latency (zero-wait ack):
//      word: accept edge T, write req at T+1, done at T+2.
//      byte/half: read at T+1, write at T+2, done at T+3.
//  - Throughput: one store in flight; st_ready returns the cycle done pulses.
// TESTING
//  1. sw addr 0x1000 data 0xDEADBEEF, ack immediate -> single write, no read;
//     mem_wdata 0xDEADBEEF; done at T+2.
//  2. sb addr 0x1003 data 0x000000AB, rdata 0x11223344 -> read 0x1000,
//     then write 0xAB223344; done at T+3.
//  3. sh addr 0x2002 data 0x0000BEEF, rdata 0x11223344 -> write 0xBEEF3344.
//     Same at 0x2000 -> 0x1122BEEF.
//  4. sh addr 0x2001, and separately st_size 11 -> misaligned pulse, mem_req
//     never 1, done stays 0.
//  5. sb with 3-cycle ack delay on read and write -> mem_req held, mem_addr
//     and mem_wdata stable; st_valid during busy ignored.
//  6. reset asserted during RD -> next cycle mem_req=0, st_ready=1, no write
//     issued, no done pulse.

Source files
------------

// File: rtl/store_merge_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_merge_unit
// Purpose  : Narrows sb/sh/sw stores onto a 32-bit word-only memory port,
//            using read-modify-write for byte and half stores.
// Revision : 1.0
// ============================================================================
module store_merge_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        st_size,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              misaligned
);

    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_size, w_size_nxt;
    logic [1:0]          r_off, w_off_nxt;
    logic [31:0]         r_data, w_data_nxt;
    logic                r_req, w_req_nxt;
    logic                r_we, w_we_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [31:0]         r_wdata, w_wdata_nxt;
    logic                r_done, w_done_nxt;
    logic                r_mis, w_mis_nxt;
    logic                w_st_mis;
    logic                w_ack;
    logic [31:0]         w_merged;

    assign w_st_mis = (st_size == 2'b11) ||
                      ((st_size == c_size_half) && st_addr[0]) ||
                      ((st_size == c_size_word) && (st_addr[1:0] != 2'b00));

    // An ack only counts while a request is actually outstanding.
    assign w_ack = r_req && mem_ack;

    // Little-endian lane merge of the latched store data into the read word.
    always_comb begin
        w_merged = mem_rdata;
        case (r_size)
            c_size_byte: w_merged[{r_off, 3'b000} +: 8]        = r_data[7:0];
            c_size_half: w_merged[{r_off[1], 4'b0000} +: 16]  = r_data[15:0];
            default:     w_merged                              = r_data;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_size_nxt  = r_size;
        w_off_nxt   = r_off;
        w_data_nxt  = r_data;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_done_nxt  = 1'b0;
        w_mis_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (st_valid) begin
                    w_size_nxt = st_size;
                    w_off_nxt  = st_addr[1:0];
                    w_data_nxt = st_data;
                    if (w_st_mis) begin
                        w_mis_nxt = 1'b1;
                    end else begin
                        w_addr_nxt = {st_addr[ADDR_W-1:2], 2'b00};
                        w_req_nxt  = 1'b1;
                        if (st_size == c_size_word) begin
                            w_we_nxt    = 1'b1;
                            w_wdata_nxt = st_data;
                            w_state_nxt = S_WR;
                        end else begin
                            w_we_nxt    = 1'b0;
                            w_state_nxt = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                if (w_ack) begin
                    w_wdata_nxt = w_merged;
                    w_we_nxt    = 1'b1;
                    w_state_nxt = S_WR;
                end
            end
            S_WR: begin
                if (w_ack) begin
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_we_nxt    = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_size  <= 2'b00;
            r_off   <= 2'b00;
            r_data  <= 32'h0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_done  <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_size  <= w_size_nxt;
            r_off   <= w_off_nxt;
            r_data  <= w_data_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_done  <= w_done_nxt;
            r_mis   <= w_mis_nxt;
        end
    end

    assign st_ready   = (r_state == S_IDLE);
    assign mem_req    = r_req;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign done       = r_done;
    assign misaligned = r_mis;

endmodule
`default_nettype wire

// File: tb/tb_store_merge_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_merge_unit
// Purpose  : Self-checking bench for store_merge_unit against a byte-lane
//            memory model with configurable ack delay.
// Revision : 1.0
// ============================================================================
module tb_store_merge_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              st_valid;
    logic              st_ready;
    logic [1:0]        st_size;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic              done;
    logic              misaligned;

    always #5 clk = ~clk;

    store_merge_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_size    (st_size),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .done       (done),
        .misaligned (misaligned)
    );

    int checks   = 0;
    int failures = 0;

    // Memory model: 16-word window addressed by byte address bits [5:2].
    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    logic        load_req     = 1'b0;
    logic        spurious_ack = 1'b0;
    int          ack_delay    = 0;
    int          wait_cnt     = 0;
    int          n_reads      = 0;
    int          n_writes     = 0;
    int          n_unstable   = 0;
    int          n_req_cycles = 0;
    int          n_done       = 0;
    logic [31:0] last_waddr   = 32'h0;
    logic [31:0] last_wdata   = 32'h0;
    logic [31:0] last_raddr   = 32'h0;
    logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;

    assign mem_ack   = (mem_req && (wait_cnt >= ack_delay)) || spurious_ack;
    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
        end
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
        if (mem_req) n_req_cycles <= n_req_cycles + 1;
        if (done)    n_done       <= n_done + 1;
        if (mem_req && mem_ack && mem_we) begin
            mem[mem_addr[5:2]] <= mem_wdata;
            n_writes           <= n_writes + 1;
            last_waddr         <= mem_addr;
            last_wdata         <= mem_wdata;
        end
        if (mem_req && mem_ack && !mem_we) begin
            n_reads    <= n_reads + 1;
            last_raddr <= mem_addr;
        end
        if (p_req && !p_ack && mem_req &&
            (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_we !== p_we))
            n_unstable <= n_unstable + 1;
        p_req   <= mem_req;
        p_ack   <= mem_ack;
        p_we    <= mem_we;
        p_addr  <= mem_addr;
        p_wdata <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference merge expressed as byte-lane overwrites of the old word.
    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [1:0] off, input logic [31:0] d);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        if (sz == 2'b00) begin
            b[off] = d[7:0];
        end else if (sz == 2'b01) begin
            b[off]      = d[7:0];
            b[off + 2'd1] = d[15:8];
        end else begin
            for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic load_word(input int idx, input logic [31:0] val);
        ref_mem[idx] = val;
        load_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Issues one store from a negedge and checks it through to completion.
    task automatic run_store(input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] data, input int dly, input bit spam,
                             output logic [31:0] wword);
        int r0, w0, u0, q0, d0, lat, exp_lat, idx;
        bit mis, found;
        logic [31:0] exp_word;
        idx  = int'(addr[5:2]);
        mis  = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
        ack_delay = dly;
        r0 = n_reads; w0 = n_writes; u0 = n_unstable; q0 = n_req_cycles; d0 = n_done;
        wword = 32'h0;
        chk("ready_before", 32'(st_ready), 32'd1);
        st_valid = 1'b1; st_size = sz; st_addr = addr; st_data = data;
        @(posedge clk);
        @(negedge clk);
        st_valid = 1'b0;
        if (mis) begin
            chk("mis_pulse", 32'(misaligned), 32'd1);
            @(negedge clk);
            chk("mis_clear", 32'(misaligned), 32'd0);
            @(negedge clk);
            chk("mis_no_req", 32'(n_req_cycles - q0), 32'd0);
            chk("mis_no_done", 32'(n_done - d0), 32'd0);
            return;
        end
        chk("no_mis", 32'(misaligned), 32'd0);
        exp_word = ref_merge(ref_mem[idx], sz, addr[1:0], data);
        exp_lat  = (sz == 2'b10) ? 2 + dly : 3 + 2 * dly;
        lat = 1; found = 1'b0;
        while (lat < 40 && !found) begin
            if (done) begin
                found = 1'b1;
                st_valid = 1'b0;
            end else begin
                if (spam) begin
                    st_valid = 1'b1; st_size = 2'b10;
                    st_addr = addr ^ 32'h4; st_data = ~data;
                end
                @(negedge clk);
                lat++;
            end
        end
        chk("done_seen", 32'(found), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("reads", 32'(n_reads - r0), (sz == 2'b10) ? 32'd0 : 32'd1);
        if (sz != 2'b10) chk("read_addr", last_raddr, {addr[31:2], 2'b00});
        chk("writes", 32'(n_writes - w0), 32'd1);
        chk("write_addr", last_waddr, {addr[31:2], 2'b00});
        chk("write_data", last_wdata, exp_word);
        chk("stable", 32'(n_unstable - u0), 32'd0);
        ref_mem[idx] = exp_word;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("mem_word", mem[idx], ref_mem[idx]);
        wword = last_wdata;
    endtask

    initial begin
        logic [31:0] w;
        int d0, w0;
        reset = 1'b1; st_valid = 1'b0; st_size = 2'b00; st_addr = 32'h0; st_data = 32'h0;
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        load_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        load_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_done_mis", {30'h0, done, misaligned}, 32'h0);

        run_store(2'b10, 32'h0000_1000, 32'hDEAD_BEEF, 0, 1'b0, w);
        chk("sw_word", w, 32'hDEAD_BEEF);
        load_word(0, 32'h1122_3344);
        run_store(2'b00, 32'h0000_1003, 32'h0000_00AB, 0, 1'b0, w);
        chk("sb_word", w, 32'hAB22_3344);
        load_word(0, 32'h1122_3344);
        run_store(2'b01, 32'h0000_2002, 32'h0000_BEEF, 0, 1'b0, w);
        chk("sh_hi_word", w, 32'hBEEF_3344);
        load_word(0, 32'h1122_3344);
        run_store(2'b01, 32'h0000_2000, 32'h0000_BEEF, 0, 1'b0, w);
        chk("sh_lo_word", w, 32'h1122_BEEF);
        run_store(2'b01, 32'h0000_2001, 32'h0000_BEEF, 0, 1'b0, w);
        run_store(2'b11, 32'h0000_2000, 32'h1234_5678, 0, 1'b0, w);
        run_store(2'b10, 32'h0000_2006, 32'h1234_5678, 0, 1'b0, w);
        run_store(2'b00, 32'h0000_3005, 32'hFFFF_FF5A, 3, 1'b1, w);

        // Stray ack while idle must not produce any activity.
        d0 = n_done; w0 = n_writes;
        spurious_ack = 1'b1;
        repeat (2) @(negedge clk);
        spurious_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_done", 32'(n_done - d0), 32'd0);
        chk("stray_ack_writes", 32'(n_writes - w0), 32'd0);

        // Reset while the read is outstanding.
        ack_delay = 5;
        d0 = n_done; w0 = n_writes;
        st_valid = 1'b1; st_size = 2'b00; st_addr = 32'h0000_1001; st_data = 32'h0000_0077;
        @(posedge clk);
        @(negedge clk);
        st_valid = 1'b0;
        chk("rd_pending", {30'h0, mem_req, mem_we}, 32'h2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_ready", 32'(st_ready), 32'd1);
        repeat (8) @(negedge clk);
        chk("abort_writes", 32'(n_writes - w0), 32'd0);
        chk("abort_done", 32'(n_done - d0), 32'd0);
        chk("abort_mem", mem[0], ref_mem[0]);

        for (int n = 0; n < 40; n++) begin
            run_store(2'($urandom_range(0, 3)), $urandom, $urandom,
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), w);
        end

        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
